jtag_scan_controller: RTL



---
 rtl/jtag_scan_if.sv | 26 ++
 rtl/jtag_scan_controller.sv | 81 ++++++++
 2 files changed

// File: rtl/jtag_scan_if.sv
// jtag_scan_if: TAP-side scan controls and solver byte/result signals for jtag_scan_controller.
// Ports: ir_is_user, capture_dr, shift_dr, update_dr and tdi come from the TAP.
// tdo goes back to the TAP. byte_valid, byte_data and end_of_input stream the upload to the solver.
// result_valid and result carry the solver's answer.
// master drives the TAP and solver side; slave is the controller.
interface jtag_scan_if #(parameter int RESULT_WIDTH = 16);
  logic ir_is_user;
  logic capture_dr;
  logic shift_dr;
  logic update_dr;
  logic tdi;
  logic tdo;
  logic byte_valid;
  logic [7:0] byte_data;
  logic end_of_input;
  logic result_valid;
  logic [RESULT_WIDTH-1:0] result;
  modport master (
    output ir_is_user, capture_dr, shift_dr, update_dr, tdi, result_valid, result,
    input tdo, byte_valid, byte_data, end_of_input
  );
  modport slave (
    input ir_is_user, capture_dr, shift_dr, update_dr, tdi, result_valid, result,
    output tdo, byte_valid, byte_data, end_of_input
  );
endinterface

// File: rtl/jtag_scan_controller.sv
// jtag_scan_controller: the first USER DR scan uploads LSB-first bytes to the solver; later scans read back the latched result.
// Ports: tck is the clock. test_logic_reset is an async active-high reset.
// jtag (jtag_scan_if.slave) carries the TAP controls, tdi/tdo, the byte stream and the solver result.
// Optional: define PARTIAL_BYTE_ERROR_EN so that an upload ending mid-byte makes readbacks return all-ones.
module jtag_scan_controller #(
  parameter int RESULT_WIDTH = 16,
  parameter int BYPASS_BITS  = 1
) (
  input logic       tck,
  input logic       test_logic_reset,
  jtag_scan_if.slave jtag
);
  localparam int SW = $clog2(BYPASS_BITS + 2);
  typedef enum logic [1:0] {IDLE, UPLOAD, WAIT_RESULT, DONE} state_t;
  state_t state_q, state_d;
  logic [SW-1:0] skip_cnt;
  logic [2:0] bit_idx;
  logic [6:0] byte_sr;
  logic [RESULT_WIDTH-1:0] result_hold, rb_shift, rb_load;
  logic have_result, rb_nonzero, cap, sh, upd, err, rb_phase;
  assign cap = jtag.ir_is_user & jtag.capture_dr;
  assign sh  = jtag.ir_is_user & jtag.shift_dr;
  assign upd = jtag.ir_is_user & jtag.update_dr;
  assign rb_phase = (state_q == WAIT_RESULT) || (state_q == DONE);
  assign jtag.tdo = rb_shift[0];
`ifdef PARTIAL_BYTE_ERROR_EN
  logic partial_err;
  always_ff @(posedge tck or posedge test_logic_reset)
    if (test_logic_reset) partial_err <= 1'b0;
    else if (upd && state_q == UPLOAD && bit_idx != 3'd0) partial_err <= 1'b1;
  assign err = partial_err;
`else
  assign err = 1'b0;
`endif
  assign rb_load = err ? '1 : (have_result ? result_hold : '0);
  always_ff @(posedge tck or posedge test_logic_reset)
    if (test_logic_reset) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE && cap) state_d = UPLOAD;
    if (state_q == UPLOAD && upd) state_d = WAIT_RESULT;
    if (state_q == WAIT_RESULT && upd && rb_nonzero) state_d = DONE;
  end
  // byte_sr holds the first seven data bits; the eighth arrives on tdi and completes byte_data directly.
  always_ff @(posedge tck or posedge test_logic_reset)
    if (test_logic_reset) begin
      skip_cnt <= '0;
      bit_idx <= '0;
      byte_sr <= '0;
      result_hold <= '0;
      have_result <= 1'b0;
      rb_shift <= '0;
      rb_nonzero <= 1'b0;
      jtag.byte_valid <= 1'b0;
      jtag.byte_data <= '0;
      jtag.end_of_input <= 1'b0;
    end else begin
      jtag.byte_valid <= 1'b0;
      jtag.end_of_input <= upd && state_q == UPLOAD;
      if (jtag.result_valid && !have_result) begin
        result_hold <= jtag.result;
        have_result <= 1'b1;
      end
      if (state_q == UPLOAD && sh) begin
        if (skip_cnt < SW'(BYPASS_BITS)) skip_cnt <= skip_cnt + SW'(1);
        else begin
          byte_sr <= {jtag.tdi, byte_sr[6:1]};
          bit_idx <= bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
            jtag.byte_data <= {jtag.tdi, byte_sr};
            jtag.byte_valid <= 1'b1;
          end
        end
      end
      if (rb_phase && cap) begin
        rb_shift <= rb_load;
        rb_nonzero <= |rb_load;
      end else if (rb_phase && sh) rb_shift <= rb_shift >> 1;
    end
endmodule
